// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver. Filters the PS/2 clock and deframes 11-bit frames.
// E0/F0 prefixes are folded into a single key event, which is published as a
// polled status word carrying a running event count.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for a start bit (0) on a clock fall
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking the stop bit and parity, then publishing
module ps2_keyboard_rx #(
   parameter int bus        = 32,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 50000
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ps2_clk,
   input  logic           ps2_data,
   output logic [bus-1:0] keydata,
   output logic           key_valid,
   output logic           frame_err
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int CW = bus - 16;
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   logic                  clk_s1_q, clk_s2_q;
   logic                  dat_s1_q, dat_s2_q;
   logic [FILTER_LEN-1:0] filt_sr_q;
   logic                  filt_clk_q;
   logic                  fall;

   state_t                state_q;
   logic [2:0]            bitcnt_q;
   logic [7:0]            data_q;
   logic                  par_q;
   logic                  ext_q, brk_q;
   logic [TW-1:0]         tmo_q;
   logic [bus-1:0]        keydata_q;
   logic                  key_valid_q, frame_err_q;

   // Two-flop synchronisers and the clock glitch filter with hysteresis.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
         filt_sr_q  <= '1;
         filt_clk_q <= 1'b1;
      end else begin
         clk_s1_q  <= ps2_clk;
         clk_s2_q  <= clk_s1_q;
         dat_s1_q  <= ps2_data;
         dat_s2_q  <= dat_s1_q;
         filt_sr_q <= {filt_sr_q[FILTER_LEN-2:0], clk_s2_q};
         if (&filt_sr_q) begin
            filt_clk_q <= 1'b1;
         end else if (~|filt_sr_q) begin
            filt_clk_q <= 1'b0;
         end
      end
   end

   // Fall strobe is high in the single cycle where the filtered clock drops.
   always_comb begin
      fall = filt_clk_q & ~|filt_sr_q;
   end

   // Frame FSM, prefix folding, inter-bit timeout and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         bitcnt_q    <= '0;
         data_q      <= '0;
         par_q       <= 1'b0;
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         tmo_q       <= '0;
         keydata_q   <= '0;
         key_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         key_valid_q <= 1'b0;
         frame_err_q <= 1'b0;

         if (fall || state_q == S_IDLE) begin
            tmo_q <= '0;
         end else if (tmo_q != TMO_MAX) begin
            tmo_q <= tmo_q + TW'(1);
         end

         if (fall) begin
            case (state_q)
               S_IDLE: begin
                  if (!dat_s2_q) begin
                     state_q  <= S_DATA;
                     bitcnt_q <= '0;
                  end
               end
               S_DATA: begin
                  data_q <= {dat_s2_q, data_q[7:1]};
                  if (bitcnt_q == 3'd7) begin
                     state_q <= S_PARITY;
                  end else begin
                     bitcnt_q <= bitcnt_q + 3'd1;
                  end
               end
               S_PARITY: begin
                  par_q   <= dat_s2_q;
                  state_q <= S_STOP;
               end
               S_STOP: begin
                  state_q <= S_IDLE;
                  if (dat_s2_q && (^{data_q, par_q})) begin
                     if (data_q == 8'hE0) begin
                        ext_q <= 1'b1;
                     end else if (data_q == 8'hF0) begin
                        brk_q <= 1'b1;
                     end else begin
                        keydata_q   <= {keydata_q[bus-1:16] + CW'(1), 6'b0, brk_q, ext_q, data_q};
                        key_valid_q <= 1'b1;
                        ext_q       <= 1'b0;
                        brk_q       <= 1'b0;
                     end
                  end else begin
                     frame_err_q <= 1'b1;
                     ext_q       <= 1'b0;
                     brk_q       <= 1'b0;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end else if (state_q != S_IDLE && tmo_q == TMO_MAX) begin
            // Stalled partial frame: drop it silently, keep any pending prefixes.
            state_q <= S_IDLE;
         end
      end
   end

   assign keydata   = keydata_q;
   assign key_valid = key_valid_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx. A 32-bit instance and an 18-bit instance (2-bit
// event count, so the count wraps every 4 events) share the same PS/2 lines.
module tb_ps2_keyboard_rx;

   localparam int FLEN   = 8;
   localparam int TMO    = 2000;
   localparam int HALF   = 30;
   localparam int GAP    = 100;
   localparam int MAXCYC = 60000;

   typedef struct packed {
      logic        is_err;
      logic [31:0] kd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [31:0] kd_a;
   logic        kv_a, fe_a;
   logic [17:0] kd_b;
   logic        kv_b, fe_b;

   int checks = 0;
   int errors = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   always #5 clk = ~clk;

   ps2_keyboard_rx #(.bus(32), .FILTER_LEN(FLEN), .TIMEOUT(TMO)) u_a (
      .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .keydata(kd_a), .key_valid(kv_a), .frame_err(fe_a));

   ps2_keyboard_rx #(.bus(18), .FILTER_LEN(FLEN), .TIMEOUT(TMO)) u_b (
      .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .keydata(kd_b), .key_valid(kv_b), .frame_err(fe_b));

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ps2_bit(input logic b, input bit glitch);
      ps2_data = b;
      wait_clk(HALF / 2);
      if (glitch) begin
         ps2_clk = 1'b0;
         wait_clk(3);
         ps2_clk = 1'b1;
      end
      wait_clk(HALF / 2);
      ps2_clk = 1'b0;
      wait_clk(HALF);
      ps2_clk = 1'b1;
   endtask

   // nbits < 8 sends a truncated frame with no parity/stop.
   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                             input int nbits, input int glitch_at);
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < nbits; i++) ps2_bit(b[i], glitch_at == i);
      if (nbits == 8) begin
         ps2_bit(par, 1'b0);
         ps2_bit(stop, 1'b0);
      end
      ps2_data = 1'b1;
      wait_clk(GAP);
   endtask

   function automatic logic odd_par(input logic [7:0] b);
      return ~^b;
   endfunction

   task automatic good(input logic [7:0] b);
      send_frame(b, odd_par(b), 1'b1, 8, -1);
   endtask

   task automatic push(input logic is_err, input logic [31:0] kd);
      q_a.push_back('{is_err, kd});
      q_b.push_back('{is_err, kd});
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: pops the scoreboard whenever either instance presents an output.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (kv_a || fe_a) begin
               if (q_a.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL a_unexpected valid=%0b err=%0b keydata=%h", kv_a, fe_a, kd_a);
               end else begin
                  e = q_a.pop_front();
                  check("a_kind", {31'b0, fe_a}, {31'b0, e.is_err});
                  check("a_valid", {31'b0, kv_a}, {31'b0, ~e.is_err});
                  check("a_keydata", kd_a, e.kd);
               end
            end
            if (kv_b || fe_b) begin
               if (q_b.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL b_unexpected valid=%0b err=%0b keydata=%h", kv_b, fe_b, kd_b);
               end else begin
                  e = q_b.pop_front();
                  check("b_kind", {31'b0, fe_b}, {31'b0, e.is_err});
                  check("b_keydata", {14'b0, kd_b}, {14'b0, e.kd[17:0]});
               end
            end
         end
      end
   end

   initial begin
      wait_clk(MAXCYC);
      checks++; errors++;
      $display("FAIL watchdog actual=%0d_cycles required=finish", MAXCYC);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      wait_clk(5);
      check("rst_keydata_a", kd_a, 32'h0);
      check("rst_keydata_b", {14'b0, kd_b}, 32'h0);
      check("rst_flags", {28'b0, kv_a, fe_a, kv_b, fe_b}, 32'h0);
      rst_n = 1'b1;
      wait_clk(20);

      // basic key
      push(1'b0, 32'h0001_001C);
      send_frame(8'h1C, 1'b0, 1'b1, 8, -1);

      // release prefix, then extended prefix
      push(1'b0, 32'h0002_021C);
      good(8'hF0);
      good(8'h1C);
      push(1'b0, 32'h0003_0175);
      good(8'hE0);
      good(8'h75);

      // bad parity, bad stop, and a prefix discarded by a rejected frame
      push(1'b1, 32'h0003_0175);
      send_frame(8'h1C, 1'b1, 1'b1, 8, -1);
      push(1'b1, 32'h0003_0175);
      send_frame(8'h1C, 1'b0, 1'b0, 8, -1);
      good(8'hF0);
      push(1'b1, 32'h0003_0175);
      send_frame(8'h1C, 1'b1, 1'b1, 8, -1);
      push(1'b0, 32'h0004_001C);
      good(8'h1C);

      // stalled partial frame times out; pending E0 survives the drop
      good(8'hE0);
      send_frame(8'h29, 1'b0, 1'b1, 4, -1);
      wait_clk(TMO + 10);
      push(1'b0, 32'h0005_0129);
      good(8'h29);

      // short low glitch between data bits
      push(1'b0, 32'h0006_001C);
      send_frame(8'h1C, 1'b0, 1'b1, 8, 3);

      // reset in the middle of the data bits
      ps2_bit(1'b0, 1'b0);
      ps2_bit(1'b1, 1'b0);
      ps2_bit(1'b0, 1'b0);
      rst_n = 1'b0;
      wait_clk(3);
      check("midrst_keydata_a", kd_a, 32'h0);
      ps2_data = 1'b1;
      wait_clk(5);
      rst_n = 1'b1;
      wait_clk(50);
      push(1'b0, 32'h0001_005A);
      good(8'h5A);

      wait_clk(50);
      check("pending_a", q_a.size(), 32'd0);
      check("pending_b", q_b.size(), 32'd0);
      check("final_keydata_a", kd_a, 32'h0001_005A);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
